// File: rtl/reaction_pkg.sv
// ============================================================================
// Module  : reaction_pkg
// Brief   : Shared types and constants for the reaction timer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package reaction_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    FALSE  = 3'd4
  } reaction_state_t;

  // Number of decimal digits in the reaction count
  localparam int BCD_DIGITS = 4;

  // Default saturation value: all nines
  localparam logic [4*BCD_DIGITS-1:0] MAX_BCD_DEFAULT = 16'h9999;

endpackage

`default_nettype wire

// File: rtl/bcd_counter.sv
// ============================================================================
// Module  : bcd_counter
// Brief   : Four-digit BCD incrementer with synchronous clear, count enable
//           and saturation at MAX_VAL (all nines by default).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_counter
  import reaction_pkg::*;
#(
  parameter logic [4*BCD_DIGITS-1:0] MAX_VAL = MAX_BCD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [4*BCD_DIGITS-1:0]   q,
  output logic                      sat
);

  logic [4*BCD_DIGITS-1:0] cnt_q;
  logic [4*BCD_DIGITS-1:0] cnt_d;
  logic [BCD_DIGITS-1:0]   inc;

  assign sat = (cnt_q == MAX_VAL);
  assign q   = cnt_q;

  // Ripple carry: a digit steps when every lower digit is about to wrap
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    logic [3:0] digit;
    assign digit = cnt_q[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign inc[i] = en & ~sat;
    end else begin : g_upper
      assign inc[i] = inc[i-1] & (cnt_q[4*(i-1) +: 4] == 4'd9);
    end
    assign cnt_d[4*i +: 4] = inc[i] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
  end

  // Count register: clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reaction_timer.sv
// ============================================================================
// Module  : reaction_timer
// Brief   : Measures player reaction time (ms, BCD) from lights-out to the
//           first button press; flags presses made while lights are lit.
//           Optional best-time register enabled by macro REACTION_BEST_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reaction_timer
  import reaction_pkg::*;
#(
  parameter logic [4*BCD_DIGITS-1:0] MAX_BCD = MAX_BCD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               lights,
  input  logic                     tick,
  input  logic                     btn,
  output logic [4*BCD_DIGITS-1:0]  bcd,
  output logic                     valid,
  output logic                     false_start,
  output logic                     busy,
  output logic                     overflow
`ifdef REACTION_BEST_EN
  ,
  output logic [4*BCD_DIGITS-1:0]  best_bcd
`endif
);

  reaction_state_t state_q, state_d;
  logic            btn_q;
  logic            valid_q, valid_d;
  logic            false_start_q, false_start_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic            press;
  logic            clr;
  logic            cnt_en;
  logic            cnt_sat;
  logic            lights_on;

  assign press     = btn & ~btn_q;
  assign lights_on = (lights != 8'h00);
  assign cnt_en    = (state_q == TIMING) & tick;

  bcd_counter #(
    .MAX_VAL (MAX_BCD)
  ) u_bcd_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (cnt_en),
    .q   (bcd),
    .sat (cnt_sat)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (lights_on) begin
          state_d = ARMED;
          clr     = 1'b1;
        end
      end
      ARMED: begin
        // A press beats lights-out in the same cycle: that is a jump start
        if (press) begin
          state_d = FALSE;
        end else if (!lights_on) begin
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (press) begin
          state_d = DONE;
        end
      end
      DONE, FALSE: begin
        if (lights_on) begin
          state_d = ARMED;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d       = (state_q == TIMING) & press;
    false_start_d = (state_d == FALSE);
    busy_d        = (state_d == ARMED) | (state_d == TIMING);

    if (clr) begin
      overflow_d = 1'b0;
    end else if ((state_q == TIMING) && cnt_sat) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, press-edge history and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      btn_q         <= 1'b0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn;
      valid_q       <= valid_d;
      false_start_q <= false_start_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign valid       = valid_q;
  assign false_start = false_start_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

`ifdef REACTION_BEST_EN
  logic [4*BCD_DIGITS-1:0] best_q;

  // Keep the smallest non-saturated capture; updates on the valid pulse edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q <= MAX_BCD;
    end else if (valid_q && !overflow_q && (bcd < best_q)) begin
      best_q <= bcd;
    end
  end

  assign best_bcd = best_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reaction_timer.sv
// ============================================================================
// Module  : tb_reaction_timer
// Brief   : Directed self-checking bench for reaction_timer.
//           Best-time checks are built when REACTION_BEST_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reaction_timer;

  logic        clk;
  logic        rst;
  logic [7:0]  lights;
  logic        tick;
  logic        btn;
  logic [15:0] bcd;
  logic        valid;
  logic        false_start;
  logic        busy;
  logic        overflow;
`ifdef REACTION_BEST_EN
  logic [15:0] best_bcd;
`endif

  int errors = 0;
  int checks = 0;

  reaction_timer dut (
    .clk         (clk),
    .rst         (rst),
    .lights      (lights),
    .tick        (tick),
    .btn         (btn),
    .bcd         (bcd),
    .valid       (valid),
    .false_start (false_start),
    .busy        (busy),
    .overflow    (overflow)
`ifdef REACTION_BEST_EN
    ,
    .best_bcd    (best_bcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a run: light on, then lights out (DUT enters TIMING)
  task automatic start_run();
    lights = 8'h01; step();
    lights = 8'h00; step();
  endtask

  task automatic test_reset();
    rst = 1'b0; lights = 8'h00; tick = 1'b0; btn = 1'b0;
    step(); step();
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL reset_false_start: got %b expected 0", false_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`ifdef REACTION_BEST_EN
    checks++; if (best_bcd !== 16'h9999) begin errors++; $display("FAIL reset_best: got %h expected 9999", best_bcd); end
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_run();
    lights = 8'h01; step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL armed_busy: got %b expected 1", busy); end
    while (lights != 8'hFF) begin
      lights = {lights[6:0], 1'b1};
      step();
    end
    // Tick in the lights-out cycle is still ARMED and must not count
    lights = 8'h00; tick = 1'b1; step();
    for (int i = 0; i < 250; i++) begin
      lights = (i >= 100 && i < 110) ? 8'h1F : 8'h00;
      step();
    end
    lights = 8'h00; tick = 1'b0; btn = 1'b1; step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL run_valid: got %b expected 1", valid); end
    checks++; if (bcd !== 16'h0250) begin errors++; $display("FAIL run_bcd: got %h expected 0250", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy: got %b expected 0", busy); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL run_false_start: got %b expected 0", false_start); end
    btn = 1'b0; tick = 1'b1; step();
    tick = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL run_valid_pulse: got %b expected 0", valid); end
    checks++; if (bcd !== 16'h0250) begin errors++; $display("FAIL run_bcd_hold: got %h expected 0250", bcd); end
  endtask

  task automatic test_false_start();
    lights = 8'h01; step();
    lights = 8'h3F; step();
    btn = 1'b1; step();
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_flag: got %b expected 1", false_start); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fs_valid: got %b expected 0", valid); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL fs_bcd: got %h expected 0000", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_busy: got %b expected 0", busy); end
    lights = 8'h00; btn = 1'b0; step();
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_hold: got %b expected 1", false_start); end
    lights = 8'h01; step();
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL fs_clear: got %b expected 0", false_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_rearm_busy: got %b expected 1", busy); end
    // Press coinciding with lights-out while ARMED is still a jump start
    lights = 8'h00; btn = 1'b1; step();
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_same_cycle: got %b expected 1", false_start); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fs_same_cycle_valid: got %b expected 0", valid); end
    btn = 1'b0; step();
  endtask

  task automatic test_carry_and_hold();
    int extra;
    start_run();
    tick = 1'b1;
    for (int i = 0; i < 9; i++) step();
    btn = 1'b1; step();
    tick = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b expected 1", valid); end
    checks++; if (bcd !== 16'h0010) begin errors++; $display("FAIL carry_bcd: got %h expected 0010", bcd); end
    extra = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (valid === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL held_btn_valids: got %0d extra pulses expected 0", extra); end
    btn = 1'b0; step();
  endtask

  task automatic test_overflow();
    start_run();
    tick = 1'b1;
    for (int i = 0; i < 10050; i++) step();
    tick = 1'b0;
    checks++; if (bcd !== 16'h9999) begin errors++; $display("FAIL ovf_bcd: got %h expected 9999", bcd); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    btn = 1'b1; step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", valid); end
    checks++; if (bcd !== 16'h9999) begin errors++; $display("FAIL ovf_capture: got %h expected 9999", bcd); end
    btn = 1'b0; step();
    lights = 8'h01; step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL ovf_bcd_clear: got %h expected 0000", bcd); end
    lights = 8'h00; btn = 1'b1; step();
    btn = 1'b0; step();
  endtask

  task automatic test_reset_mid_run();
    start_run();
    tick = 1'b1;
    for (int i = 0; i < 42; i++) step();
    tick = 1'b0;
    checks++; if (bcd !== 16'h0042) begin errors++; $display("FAIL mid_pre_bcd: got %h expected 0042", bcd); end
    // Assert reset between clock edges: outputs must clear without an edge
    rst = 1'b0; #2;
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mid_rst_bcd: got %h expected 0000", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    step();
    rst = 1'b1; step();
    start_run();
    tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tick = 1'b0; btn = 1'b1; step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_rerun_valid: got %b expected 1", valid); end
    checks++; if (bcd !== 16'h0005) begin errors++; $display("FAIL mid_rerun_bcd: got %h expected 0005", bcd); end
    btn = 1'b0; step();
  endtask

`ifdef REACTION_BEST_EN
  // One complete timed run of n ticks followed by a press
  task automatic timed_run(input int n);
    start_run();
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick = 1'b0; btn = 1'b1; step();
    btn = 1'b0; step();
  endtask

  task automatic test_best();
    rst = 1'b0; step();
    rst = 1'b1; step();
    timed_run(300);
    checks++; if (best_bcd !== 16'h0300) begin errors++; $display("FAIL best_after_300: got %h expected 0300", best_bcd); end
    timed_run(180);
    checks++; if (best_bcd !== 16'h0180) begin errors++; $display("FAIL best_after_180: got %h expected 0180", best_bcd); end
    timed_run(220);
    checks++; if (best_bcd !== 16'h0180) begin errors++; $display("FAIL best_after_220: got %h expected 0180", best_bcd); end
    lights = 8'h01; step();
    btn = 1'b1; step();
    lights = 8'h00; btn = 1'b0; step(); step();
    checks++; if (best_bcd !== 16'h0180) begin errors++; $display("FAIL best_after_fs: got %h expected 0180", best_bcd); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_false_start();
    test_carry_and_hold();
    test_overflow();
    test_reset_mid_run();
`ifdef REACTION_BEST_EN
    test_best();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reaction_timer.md
# reaction_timer

Downstream consumer of the F1 start-lights sequencer. Watches the 8-bit light bar, starts a millisecond count when all lights go out, and stops it on the first player button press. It reports the reaction time as a 4-digit BCD value for the seven-segment display, and flags a false start if the button is pressed while the lights are still lit.

## Interface
Parameters:
- `MAX_BCD`, default 16'h9999: saturation value of the reaction count.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `lights`  in  8  light bar from the sequencer's `dout`.
- `tick`  in  1  one-cycle 1 ms enable pulse from a `clktick` instance.
- `btn`  in  1  player button, already synchronised, active-high level.
- `bcd`  out  16  reaction time, four BCD digits, ms.
- `valid`  out  1  one-cycle pulse when a reaction time is captured.
- `false_start`  out  1  level; high while in state FALSE.
- `busy`  out  1  high in states ARMED and TIMING.
- `overflow`  out  1  level; count saturated during this run.
- `best_bcd`  out  16  best (minimum) valid time. Present only with `REACTION_BEST_EN`.

## Operation
- Press edge: `press = btn & ~btn_q`, where `btn_q` is `btn` registered.
- States: IDLE, ARMED, TIMING, DONE, FALSE.
  - IDLE: if `lights != 0`, go to ARMED and clear `bcd` and `overflow`.
  - ARMED:
    - `press`: go to FALSE. This takes priority over the lights check.
    - else if `lights == 0`: go to TIMING.
  - TIMING:
    - On `tick`, increment `bcd` as a BCD number: each digit wraps 9→0 with a carry into the next digit.
    - At `MAX_BCD`, hold the value and set `overflow`.
    - `press`: go to DONE and pulse `valid`.
  - DONE and FALSE: hold `bcd`. When `lights != 0` (a new run starts), go to ARMED, clear `bcd`, `overflow` and `false_start`.
- Presses in IDLE, DONE and FALSE are ignored.
- `lights` becoming nonzero during TIMING is ignored. Only a press ends timing.

## Timing
- Reset values:
  - state IDLE, `btn_q` 0, `bcd` 0, `valid` 0, `false_start` 0, `busy` 0, `overflow` 0.
  - `best_bcd` = `MAX_BCD`.
- All outputs are registered.
- `btn` rising before edge k (with `btn_q` low) is a press at edge k. After edge k, `valid` is high for exactly one cycle and `bcd` holds the final value.
- `tick` and `press` in the same TIMING cycle: the increment is applied and included in the captured `bcd`.
- `press` in the same cycle that `lights` drops to 0 while in ARMED: counts as a false start.
- First increment: the first `tick` strictly after the cycle in which TIMING is entered. Result resolution is 1 ms, truncated.
- Saturation: once at 16'h9999, further ticks leave `bcd` unchanged and `overflow` stays 1 until the next run.
- Reset asserted mid-run: all outputs return to reset values immediately, with no wait for a clock edge.

## Configuration
- Macro `REACTION_BEST_EN`.
- Defined:
  - `best_bcd` port and register exist.
  - On each `valid` pulse where the captured `bcd` < `best_bcd` and `overflow` is 0, update `best_bcd` in the same edge as the `valid` pulse, visible one cycle later.
  - False starts and overflows never update `best_bcd`.
  - Reset restores `MAX_BCD`.
- Undefined: no `best_bcd` port or logic; all other behaviour is identical.

## Structure
- Package `reaction_pkg` holds:
  - the state enum `reaction_state_t` (IDLE, ARMED, TIMING, DONE, FALSE);
  - `BCD_DIGITS = 4`;
  - the `MAX_BCD` default constant.
- Sub-module `bcd_counter`: 4-digit BCD incrementer with `clk`, `rst`, `clr`, `en`, `q[15:0]` and `sat` ports. It saturates at all-nines.
- `reaction_timer` instantiates one `bcd_counter` and contains the FSM, press-edge logic and the optional best-time register.

## Test plan
- Lights 0x01→0x03→…→0xFF→0x00, then 250 ticks, then press → `valid` pulses once, `bcd` = 16'h0250, `busy` drops, `false_start` = 0.
- Press while `lights` = 0x3F → `false_start` = 1, no `valid`, `bcd` = 0. The next nonzero `lights` clears `false_start` and state is ARMED.
- TIMING with `tick` and `press` in the same cycle after 9 ticks → `bcd` = 16'h0010, showing the digit carry. Holding `btn` high for 20 cycles produces only one `valid`.
- No press for 10050 ticks → `bcd` stays 16'h9999 and `overflow` = 1. A press then gives `valid` with `bcd` = 16'h9999.
- Reset asserted mid-TIMING at `bcd` = 16'h0042 → immediately IDLE, `bcd` = 0, `busy` = 0. After release, the next run starts counting from 0.
- With `REACTION_BEST_EN`: runs of 0300, 0180 and 0220 ms, plus one false start → `best_bcd` = 16'h0180.
